alu_issue: RTL

- Execute-stage front end that drives the single-cycle ALU: accepts decoded-fetch instructions with register read data, and maps MIPS opcode/funct to the 6-bit ALU op.
- Presents opr_a/opr_b/op to the ALU from a pipeline register, then captures result and zero flag into a writeback register.
- Forwards results to dependent instructions and applies valid/ready backpressure on both sides.
- Sits between the register-read stage and the register-file writeback port.

---
 rtl/alu_issue_pkg.sv | 61 ++++++
 rtl/alu_issue_dec.sv | 102 ++++++++++
 rtl/alu_issue.sv | 119 +++++++++++
 3 files changed

// File: rtl/alu_issue_pkg.sv
// Shared constants and types for the ALU issue stage: ALU op encodings, MIPS
// opcode/funct values and the decoded-instruction record.
package alu_issue_pkg;

    // ALU op encodings, shared with the ALU itself
    localparam logic [5:0] ALU_ADD = 6'b000000;
    localparam logic [5:0] ALU_SUB = 6'b000001;
    localparam logic [5:0] ALU_SHL = 6'b000010;
    localparam logic [5:0] ALU_LSR = 6'b000100;
    localparam logic [5:0] ALU_ASR = 6'b000110;
    localparam logic [5:0] ALU_OR  = 6'b001000;
    localparam logic [5:0] ALU_AND = 6'b010000;
    localparam logic [5:0] ALU_NOR = 6'b011000;
    localparam logic [5:0] ALU_XOR = 6'b100000;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;
    localparam logic [5:0] OPC_LUI   = 6'h0F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;

    typedef enum logic [1:0] {A_RS, A_RT, A_CONST} a_sel_e;
    typedef enum logic [1:0] {B_RT, B_RS5, B_CONST} b_sel_e;

    typedef struct packed {
        logic [5:0]  op;
        a_sel_e      a_sel;
        b_sel_e      b_sel;
        logic [31:0] a_const;
        logic [31:0] b_const;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic        we;
        logic        ill;
    } dec_t;

    // A producing stage supplies a source field when it writes that register; $0 never forwards
    function automatic logic fwd_hit(input logic valid, input logic we,
                                     input logic [4:0] dest, input logic [4:0] field);
        return valid && we && (field != 5'd0) && (dest == field);
    endfunction

endpackage

// File: rtl/alu_issue_dec.sv
// Combinational MIPS decoder: maps opcode/funct to the ALU op, picks operand
// sources, builds immediate operands and the destination/write-enable.
module alu_dec
    import alu_issue_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];

    always_comb begin
        // NOTE: every field gets a default first so no path through the case infers a latch.
        dec         = '0;
        dec.op      = ALU_ADD;
        dec.a_sel   = A_CONST;
        dec.b_sel   = B_CONST;
        dec.rs      = rs;
        dec.rt      = rt;
        dec.ill     = 1'b1;

        case (opcode)
            OPC_RTYPE: begin
                dec.ill  = 1'b0;
                dec.we   = 1'b1;
                dec.dest = rd;
                dec.a_sel = A_RS;
                dec.b_sel = B_RT;
                case (funct)
                    FN_ADD, FN_ADDU: dec.op = ALU_ADD;
                    FN_SUB, FN_SUBU: dec.op = ALU_SUB;
                    FN_AND:          dec.op = ALU_AND;
                    FN_OR:           dec.op = ALU_OR;
                    FN_XOR:          dec.op = ALU_XOR;
                    FN_NOR:          dec.op = ALU_NOR;
                    FN_SLL, FN_SRL, FN_SRA: begin
                        dec.op      = (funct == FN_SLL) ? ALU_SHL :
                                      (funct == FN_SRL) ? ALU_LSR : ALU_ASR;
                        dec.a_sel   = A_RT;
                        dec.b_sel   = B_CONST;
                        dec.b_const = {27'b0, shamt};
                    end
                    FN_SLLV, FN_SRLV, FN_SRAV: begin
                        dec.op    = (funct == FN_SLLV) ? ALU_SHL :
                                    (funct == FN_SRLV) ? ALU_LSR : ALU_ASR;
                        dec.a_sel = A_RT;
                        dec.b_sel = B_RS5;
                    end
                    default: begin
                        dec.ill   = 1'b1;
                        dec.we    = 1'b0;
                        dec.dest  = 5'd0;
                        dec.a_sel = A_CONST;
                        dec.b_sel = B_CONST;
                    end
                endcase
            end
            OPC_ADDI, OPC_ADDIU: begin
                dec.ill     = 1'b0;
                dec.we      = 1'b1;
                dec.dest    = rt;
                dec.a_sel   = A_RS;
                dec.b_const = {{16{imm[15]}}, imm};
            end
            OPC_ANDI, OPC_ORI, OPC_XORI: begin
                dec.ill     = 1'b0;
                dec.we      = 1'b1;
                dec.dest    = rt;
                dec.op      = (opcode == OPC_ANDI) ? ALU_AND :
                              (opcode == OPC_ORI)  ? ALU_OR  : ALU_XOR;
                dec.a_sel   = A_RS;
                dec.b_const = {16'b0, imm};
            end
            OPC_LUI: begin
                dec.ill     = 1'b0;
                dec.we      = 1'b1;
                dec.dest    = rt;
                dec.op      = ALU_SHL;
                dec.a_const = {16'b0, imm};
                dec.b_const = 32'd16;
            end
            default: ;
        endcase

        if (dec.dest == 5'd0) dec.we = 1'b0;
    end

endmodule

// File: rtl/alu_issue.sv
// Execute-stage front end: decodes and forwards operands into an EX register
// feeding the ALU, then captures the ALU result into a WB register.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [31:0]   instr_i,
    input  logic [DW-1:0] rs_data_i,
    input  logic [DW-1:0] rt_data_i,
    output logic [DW-1:0] opr_a_o,
    output logic [DW-1:0] opr_b_o,
    output logic [5:0]    op_o,
    input  logic [DW-1:0] res_i,
    input  logic          z_i,
    output logic          wb_valid_o,
    input  logic          wb_ready_i,
    output logic [4:0]    wb_dest_o,
    output logic [DW-1:0] wb_data_o,
    output logic          wb_we_o,
    output logic          wb_zero_o,
    output logic          wb_ill_o
);

    dec_t          dec;
    logic          ex_valid;
    logic          ex_we;
    logic          ex_ill;
    logic [4:0]    ex_dest;
    logic          ex_adv;
    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;
    logic [DW-1:0] a_next;
    logic [DW-1:0] b_next;

    alu_dec u_dec (
        .instr (instr_i),
        .dec   (dec)
    );

    assign ex_adv     = ex_valid & (~wb_valid_o | wb_ready_i);
    assign in_ready_o = reset_n & (~ex_valid | ex_adv);

    // EX holds the newest producer, so it wins over WB for the same register
    always_comb begin
        rs_val = rs_data_i;
        if (fwd_hit(ex_valid, ex_we, ex_dest, dec.rs))
            rs_val = res_i;
        else if (fwd_hit(wb_valid_o, wb_we_o, wb_dest_o, dec.rs))
            rs_val = wb_data_o;

        rt_val = rt_data_i;
        if (fwd_hit(ex_valid, ex_we, ex_dest, dec.rt))
            rt_val = res_i;
        else if (fwd_hit(wb_valid_o, wb_we_o, wb_dest_o, dec.rt))
            rt_val = wb_data_o;

        case (dec.a_sel)
            A_RS:    a_next = rs_val;
            A_RT:    a_next = rt_val;
            default: a_next = dec.a_const;
        endcase

        case (dec.b_sel)
            B_RT:    b_next = rt_val;
            B_RS5:   b_next = {{(DW-5){1'b0}}, rs_val[4:0]};
            default: b_next = dec.b_const;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: the data registers are reset too, because every data output must read 0 during reset.
        if (!reset_n) begin
            ex_valid <= 1'b0;
            ex_we    <= 1'b0;
            ex_ill   <= 1'b0;
            ex_dest  <= 5'd0;
            opr_a_o  <= '0;
            opr_b_o  <= '0;
            op_o     <= ALU_ADD;
        end else if (in_ready_o) begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            ex_valid <= in_valid_i;
            if (in_valid_i) begin
                ex_we   <= dec.we;
                ex_ill  <= dec.ill;
                ex_dest <= dec.dest;
                opr_a_o <= a_next;
                opr_b_o <= b_next;
                op_o    <= dec.op;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wb_valid_o <= 1'b0;
            wb_dest_o  <= 5'd0;
            wb_data_o  <= '0;
            wb_we_o    <= 1'b0;
            wb_zero_o  <= 1'b0;
            wb_ill_o   <= 1'b0;
        end else if (ex_adv) begin
            wb_valid_o <= 1'b1;
            wb_dest_o  <= ex_dest;
            wb_data_o  <= res_i;
            wb_we_o    <= ex_we;
            wb_zero_o  <= z_i;
            wb_ill_o   <= ex_ill;
        end else if (wb_ready_i) begin
            wb_valid_o <= 1'b0;
        end
    end

endmodule
